// File: rtl/hazard_stall_unit_if.sv
// Signals exchanged between the pipeline's ID/EX/MEM stages and the hazard stall unit.
// The pipeline side (master) presents stage fields; the hazard unit (slave) returns load enables and flushes.
interface hazard_stall_unit_if;
   logic [4:0] RsAddress_ID;
   logic [4:0] RtAddress_ID;
   logic       UsesRt_ID;
   logic       Branch_ID;
   logic       BranchTaken_ID;
   logic       Jump_ID;
   logic       RegWrite_EX;
   logic       MemRead_EX;
   logic [4:0] RdAddress_EX;
   logic       RegWrite_MEM;
   logic       MemRead_MEM;
   logic [4:0] RdAddress_MEM;
   logic       PCWrite;
   logic       IFIDWrite;
   logic       IDEX_Flush;
   logic       IFID_Flush;

   modport master (
      output RsAddress_ID, RtAddress_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, Jump_ID,
             RegWrite_EX, MemRead_EX, RdAddress_EX, RegWrite_MEM, MemRead_MEM, RdAddress_MEM,
      input  PCWrite, IFIDWrite, IDEX_Flush, IFID_Flush
   );

   modport slave (
      input  RsAddress_ID, RtAddress_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, Jump_ID,
             RegWrite_EX, MemRead_EX, RdAddress_EX, RegWrite_MEM, MemRead_MEM, RdAddress_MEM,
      output PCWrite, IFIDWrite, IDEX_Flush, IFID_Flush
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stalls IF/ID and bubbles ID/EX for load-use and ID-branch operand hazards,
// squashes wrong-path fetch after taken branches/jumps, and counts stalls.
module hazard_stall_unit #(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   hazard_stall_unit_if.slave hz,
   output logic [CNT_W-1:0]   StallCycles,
   output logic [CNT_W-1:0]   StallEvents
);
   localparam logic [0:0]       ST_RUN  = 1'b0;
   localparam logic [0:0]       ST_HOLD = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [0:0]       state_q, state_d;
   logic [1:0]       left_q, left_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W-1:0] events_q, events_d;

   logic       match_ex, match_mem;
   logic       hz_lu, hz_br_alu, hz_br_ld, hz_br_mem;
   logic [1:0] stall_len;
   logic       in_run, new_event, stall, redirect;

   assign match_ex  = (hz.RdAddress_EX != 5'd0) &&
                      ((hz.RdAddress_EX == hz.RsAddress_ID) ||
                       (hz.UsesRt_ID && (hz.RdAddress_EX == hz.RtAddress_ID)));
   assign match_mem = (hz.RdAddress_MEM != 5'd0) &&
                      ((hz.RdAddress_MEM == hz.RsAddress_ID) ||
                       (hz.UsesRt_ID && (hz.RdAddress_MEM == hz.RtAddress_ID)));

   assign hz_lu     = hz.RegWrite_EX && hz.MemRead_EX && match_ex && !hz.Branch_ID;
   assign hz_br_alu = hz.Branch_ID && hz.RegWrite_EX && !hz.MemRead_EX && match_ex;
   assign hz_br_ld  = hz.Branch_ID && hz.RegWrite_EX && hz.MemRead_EX && match_ex;
   assign hz_br_mem = hz.Branch_ID && hz.RegWrite_MEM && hz.MemRead_MEM && match_mem;

   always_comb begin
      stall_len = 2'd0;
      if (hz_lu || hz_br_alu || hz_br_mem) stall_len = 2'd1;
      if (hz_br_ld)                        stall_len = 2'd2;
   end

   // Reset masks detection so the pipeline free-runs while rst is held.
   assign in_run    = !rst && (state_q == ST_RUN);
   assign new_event = in_run && (stall_len != 2'd0);
   assign stall     = new_event || (!rst && (state_q == ST_HOLD));
   assign redirect  = (hz.Branch_ID && hz.BranchTaken_ID) || hz.Jump_ID;

   assign hz.PCWrite    = !stall;
   assign hz.IFIDWrite  = !stall;
   assign hz.IDEX_Flush = stall;
   assign hz.IFID_Flush = !rst && !stall && redirect;

   always_comb begin
      state_d = state_q;
      left_d  = left_q;
      if (state_q == ST_RUN) begin
         if (stall_len == 2'd2) begin
            state_d = ST_HOLD;
            left_d  = stall_len - 2'd1;
         end
      end else begin
         left_d = left_q - 2'd1;
         if (left_q <= 2'd1) begin
            state_d = ST_RUN;
            left_d  = 2'd0;
         end
      end
   end

   assign cycles_d = (stall && (cycles_q != CNT_MAX)) ? cycles_q + CNT_W'(1) : cycles_q;
   assign events_d = (new_event && (events_q != CNT_MAX)) ? events_q + CNT_W'(1) : events_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         left_q   <= 2'd0;
         cycles_q <= '0;
         events_q <= '0;
      end else begin
         state_q  <= state_d;
         left_q   <= left_d;
         cycles_q <= cycles_d;
         events_q <= events_d;
      end
   end

   assign StallCycles = cycles_q;
   assign StallEvents = events_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed checks of hazard_stall_unit against a cycle-count reference model,
// run on a full-width instance and on a narrow instance that exercises counter saturation.
module tb_hazard_stall_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_stall_unit_if if32 ();
   hazard_stall_unit_if if4 ();
   logic [31:0] cyc32, evt32;
   logic [3:0]  cyc4, evt4;

   hazard_stall_unit #(.CNT_W(32)) dut32 (
      .clk(clk), .rst(rst), .hz(if32.slave), .StallCycles(cyc32), .StallEvents(evt32)
   );
   hazard_stall_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .hz(if4.slave), .StallCycles(cyc4), .StallEvents(evt4)
   );

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       br;
      logic       taken;
      logic       jmp;
      logic       rw_ex;
      logic       mr_ex;
      logic [4:0] rd_ex;
      logic       rw_mem;
      logic       mr_mem;
      logic [4:0] rd_mem;
   } stim_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: number of further forced stall cycles owed, plus event/cycle tallies.
   int     m_owed = 0;
   longint m_cycles = 0;
   longint m_events = 0;
   bit     m_cnt_valid = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit reads(input stim_t s, input logic [4:0] rd);
      return (rd != 5'd0) && (rd == s.rs || (s.uses_rt && rd == s.rt));
   endfunction

   // Cycles the ID instruction must wait before its operands can be delivered.
   function automatic int wait_cycles(input stim_t s);
      int w = 0;
      bit ld_ex  = s.rw_ex && s.mr_ex && reads(s, s.rd_ex);
      bit alu_ex = s.rw_ex && !s.mr_ex && reads(s, s.rd_ex);
      bit ld_mem = s.rw_mem && s.mr_mem && reads(s, s.rd_mem);
      if (!s.br && ld_ex) w = 1;
      if (s.br && (alu_ex || ld_mem)) w = 1;
      if (s.br && ld_ex) w = 2;
      return w;
   endfunction

   function automatic longint sat(input longint v, input int width);
      longint mx = (longint'(1) << width) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic apply(input stim_t s, input logic r);
      rst = r;
      if32.RsAddress_ID = s.rs;      if4.RsAddress_ID = s.rs;
      if32.RtAddress_ID = s.rt;      if4.RtAddress_ID = s.rt;
      if32.UsesRt_ID = s.uses_rt;    if4.UsesRt_ID = s.uses_rt;
      if32.Branch_ID = s.br;         if4.Branch_ID = s.br;
      if32.BranchTaken_ID = s.taken; if4.BranchTaken_ID = s.taken;
      if32.Jump_ID = s.jmp;          if4.Jump_ID = s.jmp;
      if32.RegWrite_EX = s.rw_ex;    if4.RegWrite_EX = s.rw_ex;
      if32.MemRead_EX = s.mr_ex;     if4.MemRead_EX = s.mr_ex;
      if32.RdAddress_EX = s.rd_ex;   if4.RdAddress_EX = s.rd_ex;
      if32.RegWrite_MEM = s.rw_mem;  if4.RegWrite_MEM = s.rw_mem;
      if32.MemRead_MEM = s.mr_mem;   if4.MemRead_MEM = s.mr_mem;
      if32.RdAddress_MEM = s.rd_mem; if4.RdAddress_MEM = s.rd_mem;
   endtask

   // One pipeline cycle: drive after negedge, check before posedge, advance model at posedge.
   task automatic step(input string name, input stim_t s, input logic r);
      int  need = 0;
      bit  exp_stall;
      bit  exp_flush;
      apply(s, r);
      #1;
      if (r)               exp_stall = 1'b0;
      else if (m_owed > 0) exp_stall = 1'b1;
      else begin
         need      = wait_cycles(s);
         exp_stall = (need > 0);
      end
      exp_flush = !r && !exp_stall && ((s.br && s.taken) || s.jmp);
      chk({name, ".PCWrite"},    64'(if32.PCWrite),    64'(!exp_stall));
      chk({name, ".IFIDWrite"},  64'(if32.IFIDWrite),  64'(!exp_stall));
      chk({name, ".IDEX_Flush"}, 64'(if32.IDEX_Flush), 64'(exp_stall));
      chk({name, ".IFID_Flush"}, 64'(if32.IFID_Flush), 64'(exp_flush));
      chk({name, ".n.stall"},    64'(if4.IDEX_Flush),  64'(exp_stall));
      chk({name, ".n.flush"},    64'(if4.IFID_Flush),  64'(exp_flush));
      if (m_cnt_valid) begin
         chk({name, ".StallCycles"},   64'(cyc32), 64'(sat(m_cycles, 32)));
         chk({name, ".StallEvents"},   64'(evt32), 64'(sat(m_events, 32)));
         chk({name, ".n.StallCycles"}, 64'(cyc4),  64'(sat(m_cycles, 4)));
         chk({name, ".n.StallEvents"}, 64'(evt4),  64'(sat(m_events, 4)));
      end
      $display("[TB] %s rst=%0b stall=%0b flush=%0b cyc=%0d evt=%0d", name, r,
               if32.IDEX_Flush, if32.IFID_Flush, cyc32, evt32);
      @(posedge clk);
      if (r) begin
         m_owed = 0; m_cycles = 0; m_events = 0; m_cnt_valid = 1'b1;
      end else begin
         if (exp_stall) m_cycles++;
         if (m_owed > 0) m_owed--;
         else if (need > 0) begin
            m_events++;
            m_owed = need - 1;
         end
      end
      @(negedge clk);
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      return s;
   endfunction

   stim_t s_idle, s_lu, s_brld, s_bralu, s_z, s_nort;

   initial begin
      s_idle = idle();
      s_lu = idle(); s_lu.rs = 5'd5; s_lu.rw_ex = 1'b1; s_lu.mr_ex = 1'b1; s_lu.rd_ex = 5'd5;
      s_brld = idle(); s_brld.br = 1'b1; s_brld.rs = 5'd3; s_brld.rt = 5'd7; s_brld.uses_rt = 1'b1;
      s_brld.rw_ex = 1'b1; s_brld.mr_ex = 1'b1; s_brld.rd_ex = 5'd7;
      s_bralu = idle(); s_bralu.br = 1'b1; s_bralu.taken = 1'b1; s_bralu.rs = 5'd4;
      s_bralu.rw_ex = 1'b1; s_bralu.rd_ex = 5'd4;
      s_z = idle(); s_z.rw_ex = 1'b1; s_z.mr_ex = 1'b1;
      s_nort = idle(); s_nort.rt = 5'd9; s_nort.rw_ex = 1'b1; s_nort.mr_ex = 1'b1; s_nort.rd_ex = 5'd9;

      apply(s_idle, 1'b1);
      @(negedge clk);
      step("reset", s_idle, 1'b1);
      step("reset_done", s_idle, 1'b0);

      step("lu", s_lu, 1'b0);
      step("lu_release", s_idle, 1'b0);
      chk("lu.cycles_const", 64'(cyc32), 64'd1);
      chk("lu.events_const", 64'(evt32), 64'd1);

      step("rst", s_idle, 1'b1);
      step("brld_c0", s_brld, 1'b0);
      step("brld_c1", s_brld, 1'b0);
      s_brld.rw_ex = 1'b0; s_brld.mr_ex = 1'b0;
      step("brld_c2", s_brld, 1'b0);
      step("brld_after", s_idle, 1'b0);
      chk("brld.cycles_const", 64'(cyc32), 64'd2);
      chk("brld.events_const", 64'(evt32), 64'd1);

      step("bralu_c0", s_bralu, 1'b0);
      s_bralu.rw_ex = 1'b0;
      step("bralu_c1", s_bralu, 1'b0);

      step("zero_reg", s_z, 1'b0);
      step("no_rt", s_nort, 1'b0);

      s_brld.rw_ex = 1'b1; s_brld.mr_ex = 1'b1;
      step("midhold_c0", s_brld, 1'b0);
      step("midhold_rst", s_brld, 1'b1);
      step("midhold_after", s_idle, 1'b0);

      for (int i = 0; i < 20; i++) step("sat_lu", s_lu, 1'b0);
      step("sat_check", s_idle, 1'b0);
      chk("sat.n.cycles_const", 64'(cyc4), 64'd15);
      chk("sat.n.events_const", 64'(evt4), 64'd15);

      for (int i = 0; i < 2500; i++) begin
         stim_t s;
         s.rs      = 5'($urandom_range(0, 7));
         s.rt      = 5'($urandom_range(0, 7));
         s.uses_rt = 1'($urandom_range(0, 1));
         s.br      = 1'($urandom_range(0, 1));
         s.taken   = 1'($urandom_range(0, 1));
         s.jmp     = ($urandom_range(0, 7) == 0);
         s.rw_ex   = 1'($urandom_range(0, 1));
         s.mr_ex   = 1'($urandom_range(0, 1));
         s.rd_ex   = 5'($urandom_range(0, 7));
         s.rw_mem  = 1'($urandom_range(0, 1));
         s.mr_mem  = 1'($urandom_range(0, 1));
         s.rd_mem  = 5'($urandom_range(0, 7));
         step("rand", s, ($urandom_range(0, 99) == 0));
      end
      step("final", s_idle, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
